// File: rtl/pn_checker.sv
// pn_checker: receive-side PN sequence checker (BERT).
// Self-synchronises an LFSR to the incoming bit stream, declares lock after a
// run of correct predictions, then counts bit errors over fixed windows and
// drops lock when one 64-bit block holds too many errors.
// Optional feature macro: PN_CHK_INVERT_DETECT_EN (automatic polarity detection).
module pn_checker #(
    parameter int unsigned LOCK_COUNT  = 64,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned WINDOW_LOG2 = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkEn,
    input  logic        dataIn,
    input  logic [23:0] pnPolyTaps,
    input  logic [4:0]  pnPolyLength,
    input  logic        pnPolyMode,
    input  logic        pcmInvert,
    input  logic        restart,
    output logic        locked,
    output logic        errPulse,
    output logic        windowDone,
    output logic [31:0] windowErrors,
    output logic        invDetected
);

    localparam int unsigned MW       = $clog2(LOCK_COUNT + 1);
    localparam logic [31:0] WIN_LAST = 32'((64'd1 << WINDOW_LOG2) - 64'd1);

    typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

    state_t        state_q, state_d;
    logic [23:0]   sr_q, sr_d;
    logic [4:0]    fill_q, fill_d;
    logic [MW-1:0] match_q, match_d;
    logic [5:0]    blk_cnt_q, blk_cnt_d;
    logic [6:0]    blk_err_q, blk_err_d;
    logic [31:0]   win_cnt_q, win_cnt_d;
    logic [31:0]   win_err_q, win_err_d;
    logic [31:0]   win_errors_q, win_errors_d;
    logic          err_pulse_q, err_pulse_d;
    logic          win_done_q, win_done_d;

    logic [4:0]    len_c;
    logic [4:0]    mir_idx;
    logic [23:0]   mask;
    logic          d_bit, pred, err;
    logic [6:0]    blk_err_new;
    logic [31:0]   win_err_new;
    logic          inv_det;

`ifdef PN_CHK_INVERT_DETECT_EN
    logic          inv_q, inv_d;
    logic [MW-1:0] imatch_q, imatch_d;
    assign inv_det = inv_q;
`else
    assign inv_det = 1'b0;
`endif

    // Effective degree and tap mask (direct or mirrored within the degree)
    always_comb begin
        len_c   = (pnPolyLength >= 5'd23) ? 5'd24 : pnPolyLength + 5'd1;
        mask    = '0;
        mir_idx = '0;
        for (int unsigned k = 0; k < 24; k++) begin
            if (5'(k) < len_c) begin
                mir_idx = len_c - 5'd1 - 5'(k);
                mask[k] = pnPolyMode ? pnPolyTaps[mir_idx] : pnPolyTaps[k];
            end
        end
    end

    // Per-bit prediction and error
    always_comb begin
        d_bit       = dataIn ^ pcmInvert ^ inv_det;
        pred        = ^(sr_q & mask);
        err         = d_bit ^ pred;
        blk_err_new = blk_err_q + {6'd0, err};
        win_err_new = (win_err_q == '1) ? win_err_q : win_err_q + {31'd0, err};
    end

    // Next-state: search/lock FSM, block and window accounting
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        fill_d       = fill_q;
        match_d      = match_q;
        blk_cnt_d    = blk_cnt_q;
        blk_err_d    = blk_err_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        win_errors_d = win_errors_q;
        err_pulse_d  = 1'b0;
        win_done_d   = 1'b0;
`ifdef PN_CHK_INVERT_DETECT_EN
        inv_d        = inv_q;
        imatch_d     = imatch_q;
`endif
        if (clkEn) begin
            case (state_q)
                ST_SEARCH: begin
                    sr_d = {sr_q[22:0], d_bit};
                    if (fill_q < len_c) begin
                        fill_d = fill_q + 5'd1;
                    end else if (pnPolyLength != 5'd0) begin
                        match_d = err ? '0 : match_q + MW'(1);
`ifdef PN_CHK_INVERT_DETECT_EN
                        imatch_d = err ? imatch_q + MW'(1) : '0;
`endif
                        if (!err && match_q == MW'(LOCK_COUNT - 1)) begin
                            state_d = ST_LOCKED;
                            match_d = '0;
`ifdef PN_CHK_INVERT_DETECT_EN
                            imatch_d = '0;
                        end else if (err && imatch_q == MW'(LOCK_COUNT - 1)) begin
                            // History was captured in inverted polarity; flip it so the
                            // free-running LFSR continues in true polarity.
                            state_d  = ST_LOCKED;
                            inv_d    = 1'b1;
                            sr_d     = ~{sr_q[22:0], d_bit};
                            match_d  = '0;
                            imatch_d = '0;
`endif
                        end
                    end
                end
                ST_LOCKED: begin
                    sr_d        = {sr_q[22:0], pred};
                    err_pulse_d = err;
                    blk_cnt_d   = blk_cnt_q + 6'd1;
                    blk_err_d   = (blk_cnt_q == 6'd63) ? 7'd0 : blk_err_new;
                    if (win_cnt_q == WIN_LAST) begin
                        win_done_d   = 1'b1;
                        win_errors_d = win_err_new;
                        win_cnt_d    = '0;
                        win_err_d    = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 32'd1;
                        win_err_d = win_err_new;
                    end
                    // Loss of lock discards the window in progress, even on a window boundary
                    if (blk_cnt_q == 6'd63 && 32'(blk_err_new) >= LOSS_THRESH) begin
                        state_d      = ST_SEARCH;
                        fill_d       = '0;
                        match_d      = '0;
                        win_cnt_d    = '0;
                        win_err_d    = '0;
                        win_done_d   = 1'b0;
                        win_errors_d = win_errors_q;
`ifdef PN_CHK_INVERT_DETECT_EN
                        inv_d        = 1'b0;
                        imatch_d     = '0;
`endif
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // State registers; restart acts exactly like reset and wins over clkEn
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_q      <= ST_SEARCH;
            sr_q         <= '0;
            fill_q       <= '0;
            match_q      <= '0;
            blk_cnt_q    <= '0;
            blk_err_q    <= '0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            win_errors_q <= '0;
            err_pulse_q  <= 1'b0;
            win_done_q   <= 1'b0;
`ifdef PN_CHK_INVERT_DETECT_EN
            inv_q        <= 1'b0;
            imatch_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            fill_q       <= fill_d;
            match_q      <= match_d;
            blk_cnt_q    <= blk_cnt_d;
            blk_err_q    <= blk_err_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            win_errors_q <= win_errors_d;
            err_pulse_q  <= err_pulse_d;
            win_done_q   <= win_done_d;
`ifdef PN_CHK_INVERT_DETECT_EN
            inv_q        <= inv_d;
            imatch_q     <= imatch_d;
`endif
        end
    end

    assign locked       = (state_q == ST_LOCKED);
    assign errPulse     = err_pulse_q;
    assign windowDone   = win_done_q;
    assign windowErrors = win_errors_q;
    assign invDetected  = inv_det;

endmodule
